// File: rtl/udma_ext_per_width_conv.sv
// Width converter between 32-bit DC-FIFO words and an 8-bit peripheral byte stream.
// Optional macro UDMA_EXT_PER_MSB_FIRST_EN reverses byte order within the active bytes.
module udma_ext_per_width_conv (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [1:0]  cfg_datasize_i,
  input  logic        cfg_clr_i,
  input  logic [31:0] tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic [7:0]  byte_tx_o,
  output logic        byte_tx_valid_o,
  input  logic        byte_tx_ready_i,
  output logic        byte_tx_last_o,
  input  logic [7:0]  byte_rx_i,
  input  logic        byte_rx_valid_i,
  output logic        byte_rx_ready_o,
  output logic [31:0] rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i
);

  typedef enum logic {TX_EMPTY, TX_SEND} tx_state_e;

  function automatic logic [2:0] size_to_n(input logic [1:0] ds);
    case (ds)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  tx_state_e   tx_state_q, tx_state_d;
  logic [31:0] tx_word_q, tx_word_d;
  logic [2:0]  tx_n_q, tx_n_d;
  logic [1:0]  tx_idx_q, tx_idx_d;

  logic [31:0] rx_acc_q, rx_acc_d;
  logic [2:0]  rx_n_q, rx_n_d;
  logic [1:0]  rx_cnt_q, rx_cnt_d;
  logic        rx_full_q, rx_full_d;

  logic [1:0]  tx_lastidx, tx_sel;
  logic        tx_last, tx_byte_acc, tx_load;
  logic [2:0]  rx_n_cur;
  logic [1:0]  rx_lastidx, rx_pos;
  logic        rx_byte_acc, rx_drain;

  // ---------------- TX: word -> bytes ----------------
  assign tx_lastidx      = 2'(tx_n_q - 3'd1);
  assign tx_last         = (tx_idx_q == tx_lastidx);
  assign byte_tx_valid_o = (tx_state_q == TX_SEND);
  assign byte_tx_last_o  = byte_tx_valid_o & tx_last;
  assign tx_byte_acc     = byte_tx_valid_o & byte_tx_ready_i;
  assign tx_ready_o      = ~cfg_clr_i & ((tx_state_q == TX_EMPTY) | (tx_byte_acc & tx_last));
  assign tx_load         = tx_valid_i & tx_ready_o;

`ifdef UDMA_EXT_PER_MSB_FIRST_EN
  assign tx_sel = tx_lastidx - tx_idx_q;
`else
  assign tx_sel = tx_idx_q;
`endif
  assign byte_tx_o = tx_word_q[{tx_sel, 3'b000} +: 8];

  always_comb begin
    tx_state_d = tx_state_q;
    tx_word_d  = tx_word_q;
    tx_n_d     = tx_n_q;
    tx_idx_d   = tx_idx_q;
    if (cfg_clr_i) begin
      tx_state_d = TX_EMPTY;
      tx_word_d  = '0;
      tx_n_d     = 3'd1;
      tx_idx_d   = '0;
    end else if (tx_load) begin
      // Reload on the last-byte accept keeps back-to-back words bubble-free.
      tx_state_d = TX_SEND;
      tx_word_d  = tx_data_i;
      tx_n_d     = size_to_n(cfg_datasize_i);
      tx_idx_d   = '0;
    end else if (tx_byte_acc) begin
      if (tx_last) tx_state_d = TX_EMPTY;
      else         tx_idx_d   = tx_idx_q + 2'd1;
    end
  end

  // ---------------- RX: bytes -> word ----------------
  assign byte_rx_ready_o = ~cfg_clr_i & (~rx_full_q | rx_ready_i);
  assign rx_byte_acc     = byte_rx_valid_i & byte_rx_ready_o;
  assign rx_drain        = rx_full_q & rx_ready_i;
  assign rx_valid_o      = rx_full_q;
  assign rx_data_o       = rx_acc_q;

  // Word size is captured with the first byte; later bytes use the stored size.
  assign rx_n_cur   = (rx_cnt_q == 2'd0) ? size_to_n(cfg_datasize_i) : rx_n_q;
  assign rx_lastidx = 2'(rx_n_cur - 3'd1);
`ifdef UDMA_EXT_PER_MSB_FIRST_EN
  assign rx_pos = rx_lastidx - rx_cnt_q;
`else
  assign rx_pos = rx_cnt_q;
`endif

  always_comb begin
    rx_acc_d  = rx_acc_q;
    rx_n_d    = rx_n_q;
    rx_cnt_d  = rx_cnt_q;
    rx_full_d = rx_full_q;
    if (cfg_clr_i) begin
      rx_acc_d  = '0;
      rx_n_d    = 3'd1;
      rx_cnt_d  = '0;
      rx_full_d = 1'b0;
    end else begin
      if (rx_drain) rx_full_d = 1'b0;
      if (rx_byte_acc) begin
        // First byte clears the accumulator so unused upper bytes read as zero.
        if (rx_cnt_q == 2'd0) begin
          rx_acc_d = '0;
          rx_n_d   = rx_n_cur;
        end
        rx_acc_d[{rx_pos, 3'b000} +: 8] = byte_rx_i;
        if (rx_cnt_q == rx_lastidx) begin
          rx_cnt_d  = '0;
          rx_full_d = 1'b1;
        end else begin
          rx_cnt_d  = rx_cnt_q + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tx_state_q <= TX_EMPTY;
      tx_word_q  <= '0;
      tx_n_q     <= 3'd1;
      tx_idx_q   <= '0;
      rx_acc_q   <= '0;
      rx_n_q     <= 3'd1;
      rx_cnt_q   <= '0;
      rx_full_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_word_q  <= tx_word_d;
      tx_n_q     <= tx_n_d;
      tx_idx_q   <= tx_idx_d;
      rx_acc_q   <= rx_acc_d;
      rx_n_q     <= rx_n_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_full_q  <= rx_full_d;
    end
  end

endmodule
